ct_ifu_precode_pipe: RTL

Parametrised, pipelined successor to the IFU fetch-block precoder. It takes a fetch block of HW_NUM halfwords and produces per-halfword branch and boundary hints. It also resolves the actual instruction boundary by carrying "open 32-bit head" state across consecutive sequential fetch blocks. Sits between the ICache data-out stage and the IBUF/branch-predict path, with one registered stage and a valid/ready handshake.

---
 rtl/ct_ifu_precode_pipe_if.sv | 27 ++
 rtl/ct_ifu_precode_pipe.sv | 84 ++++++++
 2 files changed

// File: rtl/ct_ifu_precode_pipe_if.sv
// ct_ifu_precode_pipe_if: fetch-block in / precode-result out handshake bundle.
// Field width follows CT_IFU_PRECODE_IND_EN (6 bits with ind_br, else 5).
interface ct_ifu_precode_pipe_if #(parameter int HW_NUM = 8);
`ifdef CT_IFU_PRECODE_IND_EN
    localparam int PC_W = 6;
`else
    localparam int PC_W = 5;
`endif
    logic                   in_vld;
    logic                   in_rdy;
    logic [16*HW_NUM-1:0]   in_data;
    logic                   in_seq;
    logic                   flush;
    logic                   out_vld;
    logic                   out_rdy;
    logic [PC_W*HW_NUM-1:0] out_pre_code;
    logic                   out_head_tail;
    logic                   out_tail_open;
    modport master (
        output in_vld, in_data, in_seq, flush, out_rdy,
        input  in_rdy, out_vld, out_pre_code, out_head_tail, out_tail_open
    );
    modport slave (
        input  in_vld, in_data, in_seq, flush, out_rdy,
        output in_rdy, out_vld, out_pre_code, out_head_tail, out_tail_open
    );
endinterface

// File: rtl/ct_ifu_precode_pipe.sv
// ct_ifu_precode_pipe: registered fetch-block precoder with cross-block 32-bit head carry.
// CT_IFU_PRECODE_IND_EN adds an ind_br bit (jalr / c.jr / c.jalr) as the field MSB.
module ct_ifu_precode_pipe #(
    parameter int HW_NUM = 8
) (
    input logic                     forever_cpuclk,
    input logic                     cpurst_b,
    ct_ifu_precode_pipe_if.slave    bus
);
`ifdef CT_IFU_PRECODE_IND_EN
    localparam int PC_W = 6;
`else
    localparam int PC_W = 5;
`endif
    logic [15:0]             w_hw [HW_NUM];
    logic [HW_NUM-1:0]       w_ab, w_br, w_bry1, w_bry0, w_bry;
    logic [PC_W*HW_NUM-1:0]  w_pre;
    logic                    w_ht, w_open, w_acc;
    logic                    r_tail_pend, r_out_vld, r_ht, r_open;
    logic [PC_W*HW_NUM-1:0]  r_pre;
`ifdef CT_IFU_PRECODE_IND_EN
    logic [HW_NUM-1:0]       w_ind;
`endif
    // Branch classes are decoded from each halfword alone, independent of boundary.
    for (genvar k = 0; k < HW_NUM; k++) begin : g_hw
        assign w_hw[k] = bus.in_data[16*(HW_NUM-1-k)+:16];
        assign w_ab[k] = (w_hw[k][6:0] == 7'b1101111)
                      || (w_hw[k][15:13] == 3'b101 && w_hw[k][1:0] == 2'b01);
        assign w_br[k] = w_ab[k]
                      || (w_hw[k][6:0] == 7'b1100011 && w_hw[k][14:13] != 2'b01)
                      || (w_hw[k][15:14] == 2'b11 && w_hw[k][1:0] == 2'b01);
`ifdef CT_IFU_PRECODE_IND_EN
        assign w_ind[k] = (w_hw[k][6:0] == 7'b1100111 && w_hw[k][14:12] == 3'b000)
                       || (w_hw[k][15:13] == 3'b100 && w_hw[k][6:2] == 5'd0
                           && w_hw[k][11:7] != 5'd0 && w_hw[k][1:0] == 2'b10);
`endif
    end
    assign w_ht  = bus.in_seq && r_tail_pend;
    assign w_acc = bus.in_vld && bus.in_rdy && !bus.flush;
    always_comb begin
        w_bry1    = '0;
        w_bry0    = '0;
        w_pre     = '0;
        w_bry1[0] = 1'b1;
        w_bry0[1] = 1'b1;
        for (int k = 1; k < HW_NUM; k++)
            w_bry1[k] = !(w_bry1[k-1] && w_hw[k-1][1:0] == 2'b11);
        for (int k = 2; k < HW_NUM; k++)
            w_bry0[k] = !(w_bry0[k-1] && w_hw[k-1][1:0] == 2'b11);
        w_bry = w_ht ? w_bry0 : w_bry1;
        for (int k = 0; k < HW_NUM; k++)
`ifdef CT_IFU_PRECODE_IND_EN
            w_pre[PC_W*(HW_NUM-1-k)+:PC_W] = {w_ind[k], w_ab[k], w_br[k], w_bry1[k], w_bry0[k], w_bry[k]};
`else
            w_pre[PC_W*(HW_NUM-1-k)+:PC_W] = {w_ab[k], w_br[k], w_bry1[k], w_bry0[k], w_bry[k]};
`endif
    end
    assign w_open = w_bry[HW_NUM-1] && w_hw[HW_NUM-1][1:0] == 2'b11;
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_out_vld   <= 1'b0;
            r_pre       <= '0;
            r_ht        <= 1'b0;
            r_open      <= 1'b0;
            r_tail_pend <= 1'b0;
        end else if (bus.flush) begin
            r_out_vld   <= 1'b0;
            r_tail_pend <= 1'b0;
        end else if (w_acc) begin
            r_out_vld   <= 1'b1;
            r_pre       <= w_pre;
            r_ht        <= w_ht;
            r_open      <= w_open;
            r_tail_pend <= w_open;
        end else if (bus.out_rdy) begin
            r_out_vld   <= 1'b0;
        end
    end
    assign bus.in_rdy        = !r_out_vld || bus.out_rdy;
    assign bus.out_vld       = r_out_vld;
    assign bus.out_pre_code  = r_pre;
    assign bus.out_head_tail = r_ht;
    assign bus.out_tail_open = r_open;
endmodule
